seq_shift_add_mac: RTL and testbench

//  Multi-cycle radix-2 shift-add multiplier with optional accumulate, for FIR taps.

---
 rtl/seq_shift_add_mac.sv | 145 ++++++++++++++
 tb/tb_seq_shift_add_mac.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mac.sv
// Multi-cycle radix-2 shift-add multiplier with optional accumulate for FIR taps.
// One coefficient bit is consumed per clock; the product and the accumulator update on the last bit.
module seq_shift_add_mac #(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int SIGNED = 0,
    parameter int ACC_W  = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       sample,
    input  logic [B_W-1:0]       coeff,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   mult_out,
    output logic [ACC_W-1:0]     acc_out
);

    localparam int P_W       = A_W + B_W;
    localparam int CNT_W     = $clog2(B_W);
    localparam bit IS_SIGNED = (SIGNED != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [A_W-1:0]     sample_q,  sample_d;
    logic [B_W-1:0]     coeff_q,   coeff_d;
    logic               acc_en_q,  acc_en_d;
    logic               acc_clr_q, acc_clr_d;
    logic [P_W-1:0]     p_q,       p_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [P_W-1:0]     mult_q,    mult_d;
    logic [ACC_W-1:0]   acc_q,     acc_d;

    logic [P_W-1:0]     sample_ext;
    logic [P_W-1:0]     addend;
    logic [P_W-1:0]     p_step;
    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W-1:0]   acc_upd;
    logic               last_bit;

    // Datapath for one iteration: the shifted multiplicand is added, or subtracted
    // for the coefficient sign bit in two's-complement mode.
    always_comb begin
        sample_ext = {P_W{IS_SIGNED & sample_q[A_W-1]}};
        sample_ext[A_W-1:0] = sample_q;
        addend   = sample_ext << count_q;
        last_bit = (count_q == CNT_W'(B_W - 1));
        p_step   = p_q;
        if (coeff_q[count_q]) begin
            if (IS_SIGNED && last_bit) begin
                p_step = p_q - addend;
            end else begin
                p_step = p_q + addend;
            end
        end
        p_ext = {ACC_W{IS_SIGNED & p_step[P_W-1]}};
        p_ext[P_W-1:0] = p_step;
        unique case ({acc_clr_q, acc_en_q})
            2'b11:   acc_upd = p_ext;
            2'b10:   acc_upd = '0;
            2'b01:   acc_upd = acc_q + p_ext;
            default: acc_upd = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        coeff_d   = coeff_q;
        acc_en_d  = acc_en_q;
        acc_clr_d = acc_clr_q;
        p_d       = p_q;
        count_d   = count_q;
        mult_d    = mult_q;
        acc_d     = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sample_d  = sample;
                    coeff_d   = coeff;
                    acc_en_d  = acc_en;
                    acc_clr_d = acc_clr;
                    p_d       = '0;
                    count_d   = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                p_d     = p_step;
                count_d = count_q + CNT_W'(1);
                if (last_bit) begin
                    mult_d  = p_step;
                    acc_d   = acc_upd;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Results are held and new operands ignored until the consumer takes them.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sample_q  <= '0;
            coeff_q   <= '0;
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            p_q       <= '0;
            count_q   <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            coeff_q   <= coeff_d;
            acc_en_q  <= acc_en_d;
            acc_clr_q <= acc_clr_d;
            p_q       <= p_d;
            count_q   <= count_d;
            mult_q    <= mult_d;
            acc_q     <= acc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign mult_out  = mult_q;
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_seq_shift_add_mac.sv
// Bench for seq_shift_add_mac: three parameterisations share one stimulus stream and are
// checked every cycle against an arithmetic model, plus hand-computed literal checks.
module tb_seq_shift_add_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  sample = '0;
    logic [7:0]  coeff = '0;
    logic        acc_en = 1'b0;
    logic        acc_clr = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy  [3];
    logic        vld  [3];
    logic [15:0] mult [3];
    logic [19:0] acc0, acc1;
    logic [15:0] acc2;
    logic [63:0] accv [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    // inst0: unsigned/ACC_W=20, inst1: signed/ACC_W=20, inst2: unsigned/ACC_W=16
    seq_shift_add_mac #(.A_W(8), .B_W(8), .SIGNED(0), .ACC_W(20)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .sample(sample), .coeff(coeff), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(vld[0]), .out_ready(out_ready), .mult_out(mult[0]), .acc_out(acc0));
    seq_shift_add_mac #(.A_W(8), .B_W(8), .SIGNED(1), .ACC_W(20)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .sample(sample), .coeff(coeff), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(vld[1]), .out_ready(out_ready), .mult_out(mult[1]), .acc_out(acc1));
    seq_shift_add_mac #(.A_W(8), .B_W(8), .SIGNED(0), .ACC_W(16)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .sample(sample), .coeff(coeff), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(vld[2]), .out_ready(out_ready), .mult_out(mult[2]), .acc_out(acc2));

    assign accv[0] = {44'd0, acc0};
    assign accv[1] = {44'd0, acc1};
    assign accv[2] = {48'd0, acc2};

    task automatic check(input string name, input int inst, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t actual=%0d required=%0d", name, inst, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     sgn_c  [3] = '{0, 1, 0};
    int     accw_c [3] = '{20, 20, 16};
    int     m_phase [3] = '{0, 0, 0};   // 0 idle, 1 busy, 2 result pending
    int     m_rem   [3] = '{0, 0, 0};
    longint m_a [3], m_b [3];
    bit     m_en [3], m_clr [3];
    longint m_mult [3] = '{0, 0, 0};
    longint m_acc  [3] = '{0, 0, 0};

    function automatic longint prod(input int sgn, input longint a, input longint b);
        longint x = a;
        longint y = b;
        if (sgn != 0) begin
            if (x >= 128) x = x - 256;
            if (y >= 128) y = y - 256;
        end
        return x * y;
    endfunction

    function automatic longint acc_upd(input int w, input bit clr, input bit en,
                                       input longint acc, input longint p);
        longint mask = (longint'(1) <<< w) - 1;
        if (clr && en) return p & mask;
        if (clr)       return 0;
        if (en)        return (acc + p) & mask;
        return acc;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_phase[i] <= 0;
                m_rem[i]   <= 0;
                m_mult[i]  <= 0;
                m_acc[i]   <= 0;
            end else begin
                case (m_phase[i])
                    0: if (in_valid) begin
                        m_a[i]     <= longint'(sample);
                        m_b[i]     <= longint'(coeff);
                        m_en[i]    <= acc_en;
                        m_clr[i]   <= acc_clr;
                        m_rem[i]   <= 8;
                        m_phase[i] <= 1;
                    end
                    1: if (m_rem[i] == 1) begin
                        m_mult[i]  <= prod(sgn_c[i], m_a[i], m_b[i]) & 64'hFFFF;
                        m_acc[i]   <= acc_upd(accw_c[i], m_clr[i], m_en[i], m_acc[i],
                                              prod(sgn_c[i], m_a[i], m_b[i]));
                        m_phase[i] <= 2;
                    end else begin
                        m_rem[i] <= m_rem[i] - 1;
                    end
                    default: if (out_ready) m_phase[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check("in_ready",  i, 64'(rdy[i]), 64'(m_phase[i] == 0));
                check("out_valid", i, 64'(vld[i]), 64'(m_phase[i] == 2));
                check("mult_out",  i, 64'(mult[i]), m_mult[i]);
                check("acc_out",   i, accv[i], m_acc[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int lat;

    task automatic wait_result();
        lat = 0;
        while (!vld[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!vld[0]) check("out_valid_timeout", 0, 64'(vld[0]), 64'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit en, input bit clr);
        @(negedge clk);
        sample = a; coeff = b; acc_en = en; acc_clr = clr; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result();
        $display("[TB] op a=%0d b=%0d en=%0d clr=%0d -> mult=%0d/%0d/%0d acc=%0d/%0d/%0d lat=%0d",
                 a, b, en, clr, mult[0], mult[1], mult[2], acc0, acc1, acc2, lat);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 0, 64'(rdy[0]), 64'd1);
        check("reset_out_valid", 0, 64'(vld[0]), 64'd0);
        check("reset_mult", 0, 64'(mult[0]), 64'd0);
        check("reset_acc", 0, accv[0], 64'd0);

        // unsigned product, no accumulate, latency
        run_op(8'd200, 8'd255, 1'b0, 1'b0);
        check("t1_latency", 0, 64'(lat), 64'd8);
        check("t1_mult", 0, 64'(mult[0]), 64'd51000);
        check("t1_acc", 0, accv[0], 64'd0);
        check("t1_mult_signed", 1, 64'(mult[1]), 64'd56);

        // signed corner cases
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        check("t2_mult_signed", 1, 64'(mult[1]), 64'd16384);
        check("t2_mult_unsigned", 0, 64'(mult[0]), 64'd16384);
        run_op(8'hFD, 8'd5, 1'b0, 1'b0);
        check("t2_neg_signed", 1, 64'(mult[1]), 64'hFFF1);
        check("t2_neg_unsigned", 0, 64'(mult[0]), 64'd1265);

        // accumulate chain
        run_op(8'd3, 8'd4, 1'b1, 1'b1);
        check("t3_acc_12", 0, accv[0], 64'd12);
        run_op(8'd5, 8'd6, 1'b1, 1'b0);
        check("t3_acc_42", 0, accv[0], 64'd42);
        run_op(8'd7, 8'd8, 1'b1, 1'b0);
        check("t3_acc_98", 0, accv[0], 64'd98);
        run_op(8'd1, 8'd1, 1'b0, 1'b1);
        check("t3_clr_acc", 0, accv[0], 64'd0);
        check("t3_clr_mult", 0, 64'(mult[0]), 64'd1);

        // accumulator wrap at 16 bits
        run_op(8'd255, 8'd255, 1'b1, 1'b1);
        check("t6_first", 2, accv[2], 64'd65025);
        run_op(8'd255, 8'd255, 1'b1, 1'b0);
        check("t6_wrap", 2, accv[2], 64'd64514);
        check("t6_nowrap", 0, accv[0], 64'd130050);

        // backpressure with in_valid held high
        @(negedge clk);
        out_ready = 1'b0;
        sample = 8'd2; coeff = 8'd3; acc_en = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        sample = 8'd4; coeff = 8'd5;
        wait_result();
        check("t4_mult", 0, 64'(mult[0]), 64'd6);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_stall_mult", 0, 64'(mult[0]), 64'd6);
            check("t4_stall_ready", 0, 64'(rdy[0]), 64'd0);
            check("t4_stall_valid", 0, 64'(vld[0]), 64'd1);
            $display("[TB] stall cycle %0d mult=%0d in_ready=%0d out_valid=%0d", k, mult[0], rdy[0], vld[0]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_post_hs_ready", 0, 64'(rdy[0]), 64'd1);
        check("t4_post_hs_valid", 0, 64'(vld[0]), 64'd0);
        @(negedge clk);
        check("t4_reaccept", 0, 64'(rdy[0]), 64'd0);
        in_valid = 1'b0;
        wait_result();
        check("t4_second_mult", 0, 64'(mult[0]), 64'd20);
        $display("[TB] backpressure second result mult=%0d", mult[0]);

        // reset during RUN at count=3
        @(negedge clk);
        sample = 8'd7; coeff = 8'd7; acc_en = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_ready", 0, 64'(rdy[0]), 64'd1);
        check("t5_valid", 0, 64'(vld[0]), 64'd0);
        check("t5_acc", 0, accv[0], 64'd0);
        $display("[TB] mid-run reset in_ready=%0d out_valid=%0d acc=%0d", rdy[0], vld[0], acc0);
        run_op(8'd9, 8'd9, 1'b0, 1'b0);
        check("t5_mult", 0, 64'(mult[0]), 64'd81);
        check("t5_acc_after", 0, accv[0], 64'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
